// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard and forwarding control for the pipelined CPU. A small shadow
// pipeline (ex -> mem -> wb) tracks which registers are about to be written.
// From it the unit produces:
//   - registered EX-operand forwarding selects;
//   - a combinational load-use stall;
//   - a combinational, multi-cycle flush after a taken branch or jump;
//   - saturating stall/flush cycle counters for performance debug.
//
// Parameters
//   REG_ADDR_W   register address width (2**REG_ADDR_W registers)
//   FLUSH_CYCLES flush length per taken branch, 1..3
//   ZERO_REG_EN  1: register 0 is hardwired and never forwards or stalls
//   CNT_W        width of the performance counters
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   id_valid                       valid instruction in ID
//   id_rs1, id_rs2                 ID source registers
//   id_use_rs1, id_use_rs2         ID instruction really reads rs1 / rs2
//   id_rd, id_reg_write            ID destination and write enable
//   id_mem_read                    ID instruction is a load
//   branch_taken                   EX resolved a taken branch/jump
//   forward_a, forward_b           EX operand select (0 RF, 1 MEM/WB, 2 EX/MEM)
//   stall                          hold PC + IF/ID, bubble into ID/EX
//   flush                          squash IF/ID and ID/EX
//   stall_cnt, flush_cnt           saturating cycle counters
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int REG_ADDR_W   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter bit ZERO_REG_EN  = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Operand select encoding seen by the EX muxes.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_WB = 2'd1,
        FWD_EX = 2'd2
    } fwdSel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // The load flag only matters while the producer sits in EX (that is the
    // only place a load-use stall can be detected), so the later stages
    // carry just the write information.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  memRead;
    } exStage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
    } lateStage_t;

    // The branch cycle itself is the first flush cycle; the FLUSH state
    // covers the remaining FLUSH_CYCLES-1 cycles, counting down to zero.
    localparam int          FLUSH_LOAD_I = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
    localparam logic [1:0]  FLUSH_LOAD   = FLUSH_LOAD_I[1:0];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    exStage_t   ex_q,  ex_d;
    lateStage_t mem_q, wb_q;

    logic [1:0] forwardA_q, forwardA_d;
    logic [1:0] forwardB_q, forwardB_d;

    state_e     state_q, state_d;
    logic [1:0] flushCtr_q, flushCtr_d;

    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic exMatchA, exMatchB;
    logic memMatchA, memMatchB;
    logic wbMatchA, wbMatchB;
    logic loadUse;
    logic advance;
    logic [1:0] selA, selB;

    // A stage matches a source when it will really write that register and
    // the source is really read; a hardwired r0 never matches.
    function automatic logic stageMatch(
        input logic                  valid,
        input logic                  regWrite,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  used
    );
        return valid && regWrite && (rd == src) && used &&
               !(ZERO_REG_EN && (src == '0));
    endfunction

    // The youngest producer wins. A wb-stage hit still reads the register
    // file, because the file is write-through.
    function automatic logic [1:0] pickForward(
        input logic exHit,
        input logic memHit,
        input logic wbHit
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (exHit) begin
            sel = FWD_EX;
        end else if (memHit) begin
            sel = FWD_WB;
        end else if (wbHit) begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    always_comb begin
        exMatchA  = stageMatch(ex_q.valid,  ex_q.regWrite,  ex_q.rd,  id_rs1, id_use_rs1);
        exMatchB  = stageMatch(ex_q.valid,  ex_q.regWrite,  ex_q.rd,  id_rs2, id_use_rs2);
        memMatchA = stageMatch(mem_q.valid, mem_q.regWrite, mem_q.rd, id_rs1, id_use_rs1);
        memMatchB = stageMatch(mem_q.valid, mem_q.regWrite, mem_q.rd, id_rs2, id_use_rs2);
        wbMatchA  = stageMatch(wb_q.valid,  wb_q.regWrite,  wb_q.rd,  id_rs1, id_use_rs1);
        wbMatchB  = stageMatch(wb_q.valid,  wb_q.regWrite,  wb_q.rd,  id_rs2, id_use_rs2);

        loadUse = (exMatchA || exMatchB) && ex_q.memRead;

        selA = pickForward(exMatchA, memMatchA, wbMatchA);
        selB = pickForward(exMatchB, memMatchB, wbMatchB);
    end

    // Flush FSM plus stall/flush generation. During FLUSH the pending branch
    // is itself being squashed, so branch_taken is ignored and no stall is
    // raised; a branch in RUN likewise overrides any load-use stall.
    always_comb begin
        state_d    = state_q;
        flushCtr_d = flushCtr_q;
        stall      = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_RUN: begin
                flush = branch_taken;
                stall = loadUse && !branch_taken;
                if (branch_taken && (FLUSH_CYCLES > 1)) begin
                    state_d    = ST_FLUSH;
                    flushCtr_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flushCtr_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flushCtr_d = flushCtr_q - 2'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                flushCtr_d = 2'd0;
            end
        endcase
    end

    // Shadow pipeline and forward latch: the ID instruction only moves into
    // EX when neither stalled nor flushed; otherwise a bubble goes in and the
    // operand selects fall back to the register file.
    always_comb begin
        advance = !stall && !flush;

        ex_d          = '0;
        if (id_valid && advance) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd;
            ex_d.regWrite = id_reg_write;
            ex_d.memRead  = id_mem_read;
        end

        forwardA_d = FWD_RF;
        forwardB_d = FWD_RF;
        if (advance) begin
            forwardA_d = selA;
            forwardB_d = selB;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (stall && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + CNT_ONE;
        end
        if (flush && (flushCnt_q != CNT_MAX)) begin
            flushCnt_d = flushCnt_q + CNT_ONE;
        end
    end

    // All state, including an in-progress flush, is dropped on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            forwardA_q <= FWD_RF;
            forwardB_q <= FWD_RF;
            state_q    <= ST_RUN;
            flushCtr_q <= 2'd0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= '{valid: ex_q.valid, rd: ex_q.rd, regWrite: ex_q.regWrite};
            wb_q       <= mem_q;
            forwardA_q <= forwardA_d;
            forwardB_q <= forwardB_d;
            state_q    <= state_d;
            flushCtr_q <= flushCtr_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign forward_a = forwardA_q;
    assign forward_b = forwardB_q;
    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed bench for hazard_forward_unit. Two instances share one stimulus:
//   dutA: FLUSH_CYCLES=3, ZERO_REG_EN=0, CNT_W=4
//   dutB: FLUSH_CYCLES=1, ZERO_REG_EN=1, CNT_W=16
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled at the falling edge, registered outputs 1 unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       idValid;
    logic [1:0] idRs1, idRs2, idRd;
    logic       idUseRs1, idUseRs2, idRegWrite, idMemRead;
    logic       branchTaken;

    logic [1:0]  fwdAa, fwdBa, fwdAb, fwdBb;
    logic        stallA, flushA, stallB, flushB;
    logic [3:0]  stallCntA, flushCntA;
    logic [15:0] stallCntB, flushCntB;

    int total = 0;
    int bad   = 0;

    hazard_forward_unit #(
        .REG_ADDR_W  (2),
        .FLUSH_CYCLES(3),
        .ZERO_REG_EN (1'b0),
        .CNT_W       (4)
    ) dutA (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (idValid),
        .id_rs1      (idRs1),
        .id_rs2      (idRs2),
        .id_use_rs1  (idUseRs1),
        .id_use_rs2  (idUseRs2),
        .id_rd       (idRd),
        .id_reg_write(idRegWrite),
        .id_mem_read (idMemRead),
        .branch_taken(branchTaken),
        .forward_a   (fwdAa),
        .forward_b   (fwdBa),
        .stall       (stallA),
        .flush       (flushA),
        .stall_cnt   (stallCntA),
        .flush_cnt   (flushCntA)
    );

    hazard_forward_unit #(
        .REG_ADDR_W  (2),
        .FLUSH_CYCLES(1),
        .ZERO_REG_EN (1'b1),
        .CNT_W       (16)
    ) dutB (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (idValid),
        .id_rs1      (idRs1),
        .id_rs2      (idRs2),
        .id_use_rs1  (idUseRs1),
        .id_use_rs2  (idUseRs2),
        .id_rd       (idRd),
        .id_reg_write(idRegWrite),
        .id_mem_read (idMemRead),
        .branch_taken(branchTaken),
        .forward_a   (fwdAb),
        .forward_b   (fwdBb),
        .stall       (stallB),
        .flush       (flushB),
        .stall_cnt   (stallCntB),
        .flush_cnt   (flushCntB)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one ID-stage instruction plus branch_taken.
    task automatic applyStimulus(input logic v, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic u1,
                                 input logic u2, input logic [1:0] rd,
                                 input logic rw, input logic mr,
                                 input logic br);
        idValid     = v;
        idRs1       = rs1;
        idRs2       = rs2;
        idUseRs1    = u1;
        idUseRs2    = u2;
        idRd        = rd;
        idRegWrite  = rw;
        idMemRead   = mr;
        branchTaken = br;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic pulseReset();
        idle();
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        $display("[TB] hazard_forward_unit directed test start");
        idle();
        reset_n = 1'b0;
        #2;
        checkOutput("rst stall",     stallA,    0);
        checkOutput("rst flush",     flushA,    0);
        checkOutput("rst fwdA",      fwdAa,     0);
        checkOutput("rst fwdB",      fwdBa,     0);
        checkOutput("rst stallCnt",  stallCntA, 0);
        checkOutput("rst flushCnt",  flushCntA, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // ADD r1 ; ADD x,r1,.. back-to-back -> EX/MEM forward, no stall
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd1, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd1, 2'd3, 1, 0, 2'd2, 1, 0, 0);
        midCycle();
        checkOutput("b2b stall", stallA, 0);
        tick();
        checkOutput("b2b fwdA", fwdAa, 2);
        checkOutput("b2b fwdB", fwdBa, 0);
        drain();

        // One instruction in between -> MEM/WB forward
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd1, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd3, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd1, 2'd0, 1, 0, 2'd2, 1, 0, 0);
        tick();
        checkOutput("gap1 fwdA", fwdAa, 1);
        drain();

        // Two instructions in between -> register file
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd1, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd3, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd3, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd1, 2'd0, 1, 0, 2'd2, 1, 0, 0);
        tick();
        checkOutput("gap2 fwdA", fwdAa, 0);
        drain();

        // LWD r2 ; ADD reading r2 as rs2 -> one stall cycle, then fwdB=1
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd2, 1, 1, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd2, 0, 1, 2'd3, 1, 0, 0);
        midCycle();
        checkOutput("lu stall", stallA, 1);
        tick();
        checkOutput("lu stallCnt", stallCntA, 1);
        checkOutput("lu bubble fwdB", fwdBa, 0);
        midCycle();
        checkOutput("lu stall released", stallA, 0);
        tick();
        checkOutput("lu fwdB", fwdBa, 1);
        checkOutput("lu stallCnt hold", stallCntA, 1);
        drain();

        // Same sequence without using rs2 -> no stall
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd2, 1, 1, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd2, 0, 0, 2'd3, 1, 0, 0);
        midCycle();
        checkOutput("nouse stall", stallA, 0);
        tick();
        checkOutput("nouse stallCnt", stallCntA, 1);
        drain();

        // Write r0 then read r0: forwards only when r0 is not hardwired
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd1, 1, 0, 2'd3, 1, 0, 0);
        midCycle();
        checkOutput("r0 stallB", stallB, 0);
        tick();
        checkOutput("r0 fwdA zeroDis", fwdAa, 2);
        checkOutput("r0 fwdA zeroEn", fwdAb, 0);
        drain();

        // Load to r0 then read r0: only the non-hardwired unit stalls
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd0, 1, 1, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd1, 1, 0, 2'd3, 1, 0, 0);
        midCycle();
        checkOutput("r0 load stallA", stallA, 1);
        checkOutput("r0 load stallB", stallB, 0);
        tick();
        drain();
        checkOutput("r0 stallCntB", stallCntB, 1);

        // Three-cycle flush with a coincident load-use and a second branch
        pulseReset();
        checkOutput("rst2 stallCnt", stallCntA, 0);
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd2, 1, 1, 0);
        tick();
        applyStimulus(1, 2'd0, 2'd2, 0, 1, 2'd3, 1, 0, 1);
        midCycle();
        checkOutput("br flush c0", flushA, 1);
        checkOutput("br+lu stall", stallA, 0);
        tick();
        checkOutput("br fwdB", fwdBa, 0);
        applyStimulus(0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 1);
        midCycle();
        checkOutput("br flush c1", flushA, 1);
        tick();
        idle();
        midCycle();
        checkOutput("br flush c2", flushA, 1);
        tick();
        midCycle();
        checkOutput("br flush end", flushA, 0);
        checkOutput("br flushCnt", flushCntA, 3);
        checkOutput("br stallCnt", stallCntA, 0);
        tick();

        // Reset dropped in the second flush cycle
        applyStimulus(0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 1);
        tick();
        idle();
        #1;
        checkOutput("mid flush c1", flushA, 1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("abort flush", flushA, 0);
        checkOutput("abort fwdA", fwdAa, 0);
        checkOutput("abort fwdB", fwdBa, 0);
        checkOutput("abort stallCnt", stallCntA, 0);
        checkOutput("abort flushCnt", flushCntA, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Fresh dependent pair after reset
        applyStimulus(1, 2'd0, 2'd0, 0, 0, 2'd3, 1, 0, 0);
        tick();
        applyStimulus(1, 2'd3, 2'd3, 1, 1, 2'd1, 1, 0, 0);
        midCycle();
        checkOutput("post rst flush", flushA, 0);
        tick();
        checkOutput("post rst fwdA", fwdAa, 2);
        checkOutput("post rst fwdB", fwdBa, 2);
        drain();

        // Self-dependent load held in ID: stalls every other cycle
        pulseReset();
        applyStimulus(1, 2'd1, 2'd0, 1, 0, 2'd1, 1, 1, 0);
        for (int i = 0; i < 40; i++) begin
            midCycle();
            if (i == 0) checkOutput("sat stall i0", stallA, 0);
            if (i == 1) checkOutput("sat stall i1", stallA, 1);
            tick();
            if (i == 7) checkOutput("sat stallCnt 4", stallCntA, 4);
        end
        checkOutput("sat stallCnt", stallCntA, 15);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
